fft_psd_avg: RTL and testbench
==============================

# fft_psd_avg

Power-spectrum averager sitting directly downstream of the FFT core. Consumes the FFT core's natural-order complex bin stream and computes |X[k]|² per bin. Accumulates 2^N_AVG_LOG2 consecutive frames in an internal accumulator RAM, then streams the averaged power spectrum to the host/DMA side with valid/ready.

## Interface
- FFT_SIZE, 1024, bins per frame; power of two, ≥4
- DATA_WIDTH, 16, signed width of each re/im component
- N_AVG_LOG2, 2, log2 of frames averaged; 0 means single-frame power, no averaging
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- clear_i  in  1  synchronous abort: discard partial accumulation/drain, restart at frame 0 bin 0
- in_valid_i  in  1  bin valid
- in_data_i  in  2*DATA_WIDTH  complex bin {re[MSB half], im[LSB half]}, signed
- in_ready_o  out  1  block accepts a bin
- out_valid_o  out  1  averaged bin valid
- out_data_o  out  2*DATA_WIDTH  unsigned averaged power
- out_bin_o  out  log2(FFT_SIZE)  bin index of out_data_o
- out_last_o  out  1  marks bin FFT_SIZE-1
- out_ready_i  in  1  consumer ready
- peak_valid_o  out  1  one-cycle pulse: peak result valid
- peak_bin_o  out  log2(FFT_SIZE)  bin index of maximum averaged power
- peak_val_o  out  2*DATA_WIDTH  maximum averaged power

## Operation
- States ACCUM and DRAIN. Reset or clear_i → ACCUM, bin_cnt=0, frame_cnt=0. All outputs reset to 0, except in_ready_o, which is 1 on the first cycle after reset.
- ACCUM: in_ready_o=1. Each in_valid_i&&in_ready_o handshake is one bin, indexed by bin_cnt (natural order, no framing sideband).
  - p = re²+im², computed unsigned in 2*DATA_WIDTH bits. Maximum is 2^(2*DATA_WIDTH-1) at re=im=-2^(DATA_WIDTH-1); this fits without overflow.
  - Frame 0 writes p to acc[bin]. Later frames write acc[bin]+p.
  - ACC width is 2*DATA_WIDTH+N_AVG_LOG2, so no saturation is ever needed.
  - bin_cnt wraps at FFT_SIZE-1 and increments frame_cnt.
- Leaving ACCUM: when the final bin of frame 2^N_AVG_LOG2-1 is accepted, in_ready_o drops on the next cycle. After the last RAM write retires, the block moves to DRAIN.
- DRAIN: in_ready_o=0. Bins are read out 0..FFT_SIZE-1, and out_data_o = acc >> N_AVG_LOG2 (truncating).
- Leaving DRAIN: after the handshake on out_last_o the block returns to ACCUM with frame_cnt=0.
- RAM read-modify-write: bins are consecutive addresses, so there is no read-after-write hazard. No bypass is required.
- clear_i takes priority over every other event and drops out_valid_o the next cycle. A partial frame in flight is lost, and upstream must restart the frame.
- rst_i mid-operation behaves like clear_i, plus all registers are reset. RAM contents are don't-care because frame 0 overwrites them.

## Timing
- Accumulate pipeline: handshake in cycle t → p registered and RAM read issued in t → add and write in t+1.
  - Throughput 1 bin/cycle.
  - Last write completes in t+1 of the final bin; DRAIN is entered in t+2.
- Drain: a read is issued in cycle t when state==DRAIN, more bins remain, and !(out_valid_o && !out_ready_i). out_valid_o rises in t+1.
  - out_data_o is driven from the held RAM read data, so the data holds while stalled.
  - Throughput 1 bin/cycle with out_ready_i high. First out_valid_o appears 1 cycle after DRAIN entry.
- While out_valid_o && !out_ready_i, out_data_o, out_bin_o and out_last_o are stable.

## Configuration
- FFT_PSD_PEAK_EN defined:
  - Tracks the maximum out_data_o over the drained bins. Strict greater-than compare, so ties keep the lowest bin.
  - peak_valid_o pulses the cycle after the out_last_o handshake, with peak_bin_o/peak_val_o held until the next drain completes.
- Undefined: the peak ports remain present, tied to 0, and no peak logic is generated.

## Structure
- Shared package fft_psd_pkg holds:
  - psd_state_e {ACCUM, DRAIN}
  - width helper functions: acc width and power width from DATA_WIDTH/N_AVG_LOG2
- Sub-module fft_psd_ram: simple dual-port RAM with one write port and one read port, 1-cycle registered read, read-enable holding rdata. Depth FFT_SIZE, width = acc width.

## Test plan
All scenarios use FFT_SIZE=8, DATA_WIDTH=16, N_AVG_LOG2=2.
- Ramp: 4 frames with bin k = {re=k, im=0}, out_ready_i=1 → 8 outputs, out_data_o=k² (0,1,4,…,49), out_last_o only on bin 7.
- Varying frames: frame f, all bins re=im=f+1 → powers 2,8,18,32, sum 60 → every output = 15.
- Full scale: re=im=-32768 in all frames → every output = 0x8000_0000, no wrap.
- Backpressure: out_ready_i toggling 1,0,1,0 during drain, with in_valid_i held high → bins 0..7 delivered exactly once in order, data stable while stalled, in_ready_o=0 for the whole drain.
- Abort: clear_i asserted at frame 2 bin 3, then 4 clean ramp frames → outputs identical to the ramp scenario.
- Peak (FFT_PSD_PEAK_EN defined):
  - Bin 5 = {re=100, im=0}, others 1 → peak_bin_o=5, peak_val_o=10000, one peak_valid_o pulse.
  - Equal maxima on bins 2 and 5 → peak_bin_o=2.

Source files
------------

// File: rtl/fft_psd_pkg.sv
// Shared types and width helpers for the FFT power-spectrum averager.
package fft_psd_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } psd_state_e;

  // Width of |X|^2 = re^2 + im^2 for signed components of width dw.
  function automatic int pwr_width(input int dw);
    return 2 * dw;
  endfunction

  // Accumulator width: power width plus headroom for 2^n frames.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + n;
  endfunction

endpackage

// File: rtl/fft_psd_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port,
// registered read data that holds while the read enable is low.
module fft_psd_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 34
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read, held when not enabled
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/fft_psd_avg.sv
// Power-spectrum averager: accumulates |X[k]|^2 over 2^N_AVG_LOG2 FFT frames
// in RAM, then drains the averaged spectrum over a valid/ready stream.
// Optional peak tracker enabled by defining FFT_PSD_PEAK_EN.
module fft_psd_avg
  import fft_psd_pkg::*;
#(
  parameter int FFT_SIZE   = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int N_AVG_LOG2 = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        in_valid_i,
  input  logic [2*DATA_WIDTH-1:0]     in_data_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  output logic [2*DATA_WIDTH-1:0]     out_data_o,
  output logic [$clog2(FFT_SIZE)-1:0] out_bin_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i,
  output logic                        peak_valid_o,
  output logic [$clog2(FFT_SIZE)-1:0] peak_bin_o,
  output logic [2*DATA_WIDTH-1:0]     peak_val_o
);

  localparam int BW = $clog2(FFT_SIZE);
  localparam int PW = pwr_width(DATA_WIDTH);
  localparam int AW = acc_width(DATA_WIDTH, N_AVG_LOG2);
  localparam int FW = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_SIZE - 1);
  localparam logic [FW-1:0] LAST_FRM = FW'((1 << N_AVG_LOG2) - 1);

  psd_state_e    state_q;
  logic [BW-1:0] bin_cnt_q;
  logic [FW-1:0] frame_cnt_q;
  logic [PW-1:0] pwr_q;
  logic [BW-1:0] wr_addr_q;
  logic          first_q;
  logic          wr_pend_q;
  logic          last_wr_q;
  logic [BW-1:0] rd_bin_q;
  logic          rd_done_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [BW-1:0] out_bin_q;
  logic          out_last_q;

  // Power of the incoming bin
  logic signed [DATA_WIDTH-1:0] re_s, im_s;
  logic signed [PW-1:0]         re_w, im_w, re_sq, im_sq;
  logic [PW-1:0]                pwr_d;

  assign re_s  = in_data_i[PW-1:DATA_WIDTH];
  assign im_s  = in_data_i[DATA_WIDTH-1:0];
  assign re_w  = PW'(re_s);
  assign im_w  = PW'(im_s);
  assign re_sq = re_w * re_w;
  assign im_sq = im_w * im_w;
  assign pwr_d = $unsigned(re_sq) + $unsigned(im_sq);

  logic hs_in, acc_done, drain_issue, out_hs, out_end;

  assign hs_in       = in_valid_i && in_ready_q && (state_q == ACCUM);
  assign acc_done    = hs_in && (bin_cnt_q == LAST_BIN) && (frame_cnt_q == LAST_FRM);
  assign drain_issue = (state_q == DRAIN) && !rd_done_q && !(out_valid_q && !out_ready_i);
  assign out_hs      = out_valid_q && out_ready_i;
  assign out_end     = out_hs && out_last_q;

  // RAM ports: read for RMW in ACCUM, read-out in DRAIN; write one cycle later
  logic          ram_re;
  logic [BW-1:0] ram_raddr;
  logic [AW-1:0] ram_rdata;
  logic [AW-1:0] ram_wdata;

  assign ram_re    = hs_in || drain_issue;
  assign ram_raddr = (state_q == DRAIN) ? rd_bin_q : bin_cnt_q;
  assign ram_wdata = first_q ? AW'(pwr_q) : (ram_rdata + AW'(pwr_q));

  fft_psd_ram #(
    .DEPTH (FFT_SIZE),
    .WIDTH (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_pend_q),
    .waddr_i (wr_addr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Control: frame/bin counting, accumulate pipeline, state transitions
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= ACCUM;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      pwr_q       <= '0;
      wr_addr_q   <= '0;
      first_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      last_wr_q   <= 1'b0;
      rd_bin_q    <= '0;
      rd_done_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      wr_pend_q <= hs_in;
      last_wr_q <= acc_done;
      if (hs_in) begin
        pwr_q     <= pwr_d;
        wr_addr_q <= bin_cnt_q;
        first_q   <= (frame_cnt_q == '0);
        bin_cnt_q <= bin_cnt_q + 1'b1;
        if (bin_cnt_q == LAST_BIN) begin
          frame_cnt_q <= (frame_cnt_q == LAST_FRM) ? '0 : frame_cnt_q + 1'b1;
        end
      end
      if (acc_done) begin
        in_ready_q <= 1'b0;
      end
      // Final RMW write retires this cycle; drain starts next
      if (last_wr_q) begin
        state_q <= DRAIN;
      end
      if (drain_issue) begin
        rd_bin_q <= rd_bin_q + 1'b1;
        if (rd_bin_q == LAST_BIN) begin
          rd_done_q <= 1'b1;
        end
      end
      if (out_end) begin
        state_q     <= ACCUM;
        in_ready_q  <= 1'b1;
        rd_done_q   <= 1'b0;
        rd_bin_q    <= '0;
        bin_cnt_q   <= '0;
        frame_cnt_q <= '0;
      end
    end
  end

  // Output stream registers; data comes straight from the held RAM read
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (drain_issue) begin
      out_valid_q <= 1'b1;
      out_bin_q   <= rd_bin_q;
      out_last_q  <= (rd_bin_q == LAST_BIN);
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_bin_o   = out_bin_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_valid_q ? PW'(ram_rdata >> N_AVG_LOG2) : '0;

`ifdef FFT_PSD_PEAK_EN
  logic [PW-1:0] run_max_q, cand_max, peak_val_q;
  logic [BW-1:0] run_bin_q, cand_bin, peak_bin_q;
  logic          peak_valid_q;
  logic          take_new;

  // Bin 0 restarts the running max; strict compare keeps the lowest tied bin
  assign take_new = (out_bin_q == '0) || (out_data_o > run_max_q);
  assign cand_max = take_new ? out_data_o : run_max_q;
  assign cand_bin = take_new ? out_bin_q  : run_bin_q;

  // Running maximum over drained bins, published after the last handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_max_q    <= '0;
      run_bin_q    <= '0;
      peak_val_q   <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
    end else if (clear_i) begin
      run_max_q    <= '0;
      run_bin_q    <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (out_hs) begin
        run_max_q <= cand_max;
        run_bin_q <= cand_bin;
        if (out_last_q) begin
          peak_val_q   <= cand_max;
          peak_bin_q   <= cand_bin;
          peak_valid_q <= 1'b1;
        end
      end
    end
  end

  assign peak_valid_o = peak_valid_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_val_o   = peak_val_q;
`else
  assign peak_valid_o = 1'b0;
  assign peak_bin_o   = '0;
  assign peak_val_o   = '0;
`endif

endmodule

// File: tb/tb_fft_psd_avg.sv
// Self-checking bench for fft_psd_avg (FFT_SIZE=8, DATA_WIDTH=16, N_AVG_LOG2=2).
module tb_fft_psd_avg;

  localparam int FFT = 8;
  localparam int DW  = 16;
  localparam int NAV = 2;
  localparam int NFR = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [31:0]   in_data_i = '0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [31:0]   out_data_o;
  logic [2:0]    out_bin_o;
  logic          out_last_o;
  logic          out_ready_i = 1'b1;
  logic          peak_valid_o;
  logic [2:0]    peak_bin_o;
  logic [31:0]   peak_val_o;

  fft_psd_avg #(
    .FFT_SIZE   (FFT),
    .DATA_WIDTH (DW),
    .N_AVG_LOG2 (NAV)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_bin_o    (out_bin_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i),
    .peak_valid_o (peak_valid_o),
    .peak_bin_o   (peak_bin_o),
    .peak_val_o   (peak_val_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] re_a [NFR][FFT];
  logic signed [15:0] im_a [NFR][FFT];
  logic [31:0]        expv [FFT];
  int                 exp_pk_bin;
  logic [31:0]        exp_pk_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expct);
    total++;
    assert (obs === expct) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expct);
    end
  endtask

  // Reference: average of |X|^2 over the frames, truncated; peak = first max
  task automatic compute_expected();
    longint s;
    for (int k = 0; k < FFT; k++) begin
      s = 0;
      for (int f = 0; f < NFR; f++) begin
        s += longint'(re_a[f][k]) * longint'(re_a[f][k]) + longint'(im_a[f][k]) * longint'(im_a[f][k]);
      end
      expv[k] = 32'(s / NFR);
    end
    exp_pk_bin = 0;
    exp_pk_val = expv[0];
    for (int k = 1; k < FFT; k++) begin
      if (expv[k] > exp_pk_val) begin
        exp_pk_val = expv[k];
        exp_pk_bin = k;
      end
    end
  endtask

  task automatic fill_ramp();
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = 16'(k);
        im_a[f][k] = '0;
      end
  endtask

  // Feed the first nbins of the frame tables, honouring in_ready_o
  task automatic feed(input int nbins);
    int guard;
    for (int n = 0; n < nbins; n++) begin
      @(negedge clk_i);
      in_valid_i = 1'b1;
      in_data_i  = {re_a[n / FFT][n % FFT], im_a[n / FFT][n % FFT]};
      guard = 0;
      while (!in_ready_o && guard < 100) begin
        @(negedge clk_i);
        guard++;
      end
      if (guard >= 100) begin
        check("in_ready_timeout", 64'(guard), 64'd0);
        return;
      end
    end
  endtask

  // mode: 0 ready always high, 1 ready toggling 1,0,..., 2 random ready
  task automatic run_scenario(input string name, input int mode);
    int idx, cyc;
    bit prev_stall;
    logic [31:0] sv_data;
    logic [2:0]  sv_bin;
    compute_expected();
    feed(NFR * FFT);
    idx = 0;
    cyc = 0;
    prev_stall = 0;
    sv_data = '0;
    sv_bin = '0;
    while (idx < FFT && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      in_valid_i  = 1'b1;
      in_data_i   = $urandom;
      out_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom % 2);
      check({name, ":in_ready_drain"}, 64'(in_ready_o), 64'd0);
      if (out_valid_o) begin
        check({name, ":bin"},  64'(out_bin_o), 64'(idx));
        check({name, ":data"}, 64'(out_data_o), 64'(expv[idx]));
        check({name, ":last"}, 64'(out_last_o), 64'(idx == FFT - 1));
        if (prev_stall) begin
          check({name, ":stall_data"}, 64'(out_data_o), 64'(sv_data));
          check({name, ":stall_bin"},  64'(out_bin_o),  64'(sv_bin));
        end
        prev_stall = !out_ready_i;
        sv_data = out_data_o;
        sv_bin  = out_bin_o;
        if (out_ready_i) idx++;
      end else begin
        prev_stall = 0;
      end
    end
    if (idx < FFT) check({name, ":drain_timeout"}, 64'(idx), 64'(FFT));
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check({name, ":in_ready_after"},  64'(in_ready_o),  64'd1);
    check({name, ":out_valid_after"}, 64'(out_valid_o), 64'd0);
`ifdef FFT_PSD_PEAK_EN
    check({name, ":peak_valid"}, 64'(peak_valid_o), 64'd1);
    check({name, ":peak_bin"},   64'(peak_bin_o),   64'(exp_pk_bin));
    check({name, ":peak_val"},   64'(peak_val_o),   64'(exp_pk_val));
    @(negedge clk_i);
    check({name, ":peak_pulse"}, 64'(peak_valid_o), 64'd0);
    check({name, ":peak_hold"},  64'(peak_bin_o),   64'(exp_pk_bin));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst:in_ready",   64'(in_ready_o),   64'd1);
    check("rst:out_valid",  64'(out_valid_o),  64'd0);
    check("rst:out_data",   64'(out_data_o),   64'd0);
    check("rst:out_bin",    64'(out_bin_o),    64'd0);
    check("rst:out_last",   64'(out_last_o),   64'd0);
    check("rst:peak_valid", 64'(peak_valid_o), 64'd0);
    check("rst:peak_val",   64'(peak_val_o),   64'd0);

    // Ramp: out = k^2
    fill_ramp();
    run_scenario("ramp", 0);

    // Varying frames: re=im=f+1 -> average 15
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = 16'(f + 1);
        im_a[f][k] = 16'(f + 1);
      end
    run_scenario("varying", 0);

    // Full scale: 0x8000_0000 everywhere
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = 16'sh8000;
        im_a[f][k] = 16'sh8000;
      end
    run_scenario("fullscale", 0);

    // Backpressure on the ramp
    fill_ramp();
    run_scenario("backpressure", 1);

    // Abort at frame 2 bin 3, then clean ramp
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = 16'($urandom);
        im_a[f][k] = 16'($urandom);
      end
    feed(2 * FFT + 3);
    @(negedge clk_i);
    clear_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = $urandom;
    @(negedge clk_i);
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    check("abort:in_ready",  64'(in_ready_o),  64'd1);
    check("abort:out_valid", 64'(out_valid_o), 64'd0);
    fill_ramp();
    run_scenario("after_abort", 0);

    // Clear in the middle of a drain
    feed(NFR * FFT);
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("drainclr:valid_before", 64'(out_valid_o), 64'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    out_ready_i = 1'b1;
    check("drainclr:out_valid", 64'(out_valid_o), 64'd0);
    check("drainclr:in_ready",  64'(in_ready_o),  64'd1);
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = 16'(k + f);
        im_a[f][k] = -16'(k);
      end
    run_scenario("after_drainclr", 0);

    // Random data with random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < NFR; f++)
        for (int k = 0; k < FFT; k++) begin
          re_a[f][k] = 16'($urandom);
          im_a[f][k] = 16'($urandom);
        end
      run_scenario("random", 2);
    end

    // Single peak at bin 5
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = (k == 5) ? 16'sd100 : 16'sd1;
        im_a[f][k] = '0;
      end
    run_scenario("peak5", 0);
    check("peak5:model_val", 64'(expv[5]), 64'd10000);

    // Tied maxima on bins 2 and 5: lowest bin wins
    for (int f = 0; f < NFR; f++)
      for (int k = 0; k < FFT; k++) begin
        re_a[f][k] = (k == 2 || k == 5) ? 16'sd77 : 16'sd3;
        im_a[f][k] = 16'sd2;
      end
    run_scenario("peaktie", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
